score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 191 +++++++++++++++++++
 tb/tb_score_keeper.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// BCD score accumulator: queues scoring events, adds them one BCD digit per cycle, tracks high score.
// Optional extra-life award is built when SCORE_EXTRA_LIFE_EN is defined. MODE encoding: 0 loading, 1 ready, 2 play, 3 fail.
module score_keeper (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  MODE,
   input  logic        clear,
   input  logic        pellet_eaten,
   input  logic        power_eaten,
   input  logic        fruit_eaten,
   input  logic        ghost_eaten,
   output logic [15:0] score,
   output logic [15:0] high_score,
   output logic        busy,
   output logic        drop,
   output logic        extra_life
);

   localparam logic [2:0] GAME_MODE_LOADING = 3'd0;
   localparam logic [2:0] GAME_MODE_READY   = 3'd1;
   localparam logic [2:0] GAME_MODE_FAIL    = 3'd3;

   typedef enum logic [1:0] {StIdle, StLoad, StAdd, StCommit} state_e;

   state_e      state_q, state_d;
   logic [3:0]  flags_q, flags_d;  // {ghost, power, fruit, pellet}
   logic [1:0]  combo_q, combo_d;
   logic [15:0] addend_q, addend_d;
   logic [15:0] acc_q, acc_d;
   logic        carry_q, carry_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] score_q, score_d;
   logic [15:0] high_q, high_d;
   logic        commit_q, commit_d;
   logic        drop_q, drop_d;

   logic        play;
   logic [3:0]  ev;
   logic [3:0]  accept;
   logic [3:0]  svc;
   logic [4:0]  dsum;

   always_comb begin
      play   = !(MODE == GAME_MODE_LOADING || MODE == GAME_MODE_READY || MODE == GAME_MODE_FAIL);
      ev     = {ghost_eaten, power_eaten, fruit_eaten, pellet_eaten} & {4{play}};
      accept = ev & ~flags_q;
      dsum   = {1'b0, acc_q[{idx_q, 2'b00} +: 4]} + {1'b0, addend_q[{idx_q, 2'b00} +: 4]}
               + {4'b0000, carry_q};

      state_d  = state_q;
      flags_d  = flags_q | accept;
      combo_d  = combo_q;
      addend_d = addend_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      score_d  = score_q;
      commit_d = 1'b0;
      drop_d   = drop_q | (|(ev & flags_q));
      svc      = 4'b0000;

      unique case (state_q)
         StIdle: begin
            if (|flags_d) state_d = StLoad;
         end
         StLoad: begin
            if (flags_q[3]) begin
               svc = 4'b1000;
               unique case (combo_q)
                  2'd0:    addend_d = 16'h0200;
                  2'd1:    addend_d = 16'h0400;
                  2'd2:    addend_d = 16'h0800;
                  default: addend_d = 16'h1600;
               endcase
               if (combo_q != 2'd3) combo_d = combo_q + 2'd1;
            end else if (flags_q[2]) begin
               // Servicing a power pellet also restarts the ghost chain.
               svc      = 4'b0100;
               addend_d = 16'h0050;
               combo_d  = 2'd0;
            end else if (flags_q[1]) begin
               svc      = 4'b0010;
               addend_d = 16'h0100;
            end else begin
               svc      = 4'b0001;
               addend_d = 16'h0010;
            end
            flags_d = (flags_q & ~svc) | accept;
            acc_d   = score_q;
            carry_d = 1'b0;
            idx_d   = 2'd0;
            state_d = StAdd;
         end
         StAdd: begin
            // Adding 6 modulo 16 is the BCD correction for a digit sum above 9.
            if (dsum > 5'd9) begin
               acc_d[{idx_q, 2'b00} +: 4] = dsum[3:0] + 4'd6;
               carry_d = 1'b1;
            end else begin
               acc_d[{idx_q, 2'b00} +: 4] = dsum[3:0];
               carry_d = 1'b0;
            end
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = StCommit;
         end
         StCommit: begin
            score_d  = carry_q ? 16'h9999 : acc_q;
            commit_d = 1'b1;
            state_d  = StIdle;
         end
      endcase

      if (accept[2]) combo_d = 2'd0;

      if (clear) begin
         state_d  = StIdle;
         flags_d  = 4'b0000;
         combo_d  = 2'd0;
         score_d  = 16'h0000;
         commit_d = 1'b0;
         drop_d   = drop_q;
      end

      high_d = (commit_q && (score_q > high_q)) ? score_q : high_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         flags_q  <= 4'b0000;
         combo_q  <= 2'd0;
         addend_q <= 16'h0000;
         acc_q    <= 16'h0000;
         carry_q  <= 1'b0;
         idx_q    <= 2'd0;
         score_q  <= 16'h0000;
         high_q   <= 16'h0000;
         commit_q <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         flags_q  <= flags_d;
         combo_q  <= combo_d;
         addend_q <= addend_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         score_q  <= score_d;
         high_q   <= high_d;
         commit_q <= commit_d;
         drop_q   <= drop_d;
      end
   end

   assign score      = score_q;
   assign high_score = high_q;
   assign busy       = (|flags_q) || (state_q != StIdle);
   assign drop       = drop_q;

`ifdef SCORE_EXTRA_LIFE_EN
   logic award_q, award_d;
   logic extra_q, extra_d;

   always_comb begin
      award_d = award_q;
      extra_d = 1'b0;
      if (clear) begin
         award_d = 1'b0;
      end else if (state_q == StCommit && !award_q && score_q[15:12] == 4'd0
                   && score_d[15:12] != 4'd0) begin
         award_d = 1'b1;
         extra_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         award_q <= 1'b0;
         extra_q <= 1'b0;
      end else begin
         award_q <= award_d;
         extra_q <= extra_d;
      end
   end

   assign extra_life = extra_q;
`else
   assign extra_life = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized event bursts
// compared against a decimal-arithmetic reference model.
module tb_score_keeper;

   localparam logic [2:0] ModePlay = 3'd2;
`ifdef SCORE_EXTRA_LIFE_EN
   localparam bit ExtraLife = 1'b1;
`else
   localparam bit ExtraLife = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, clear, pellet, power, fruit, ghost;
   logic [2:0]  mode;
   logic [15:0] score, high_score;
   logic        busy, drop, extra_life;

   int n_cmp = 0;
   int n_bad = 0;
   int lives_seen = 0;

   // Reference model state, in plain decimal.
   int m_score = 0, m_high = 0, m_combo = 0, m_lives = 0;
   bit m_drop = 0, m_award = 0;

   logic [3:0]  r_ev;
   logic [2:0]  r_md;
   int          r_dup;

   always #5 clk = ~clk;

   always @(negedge clk) if (extra_life === 1'b1) lives_seen <= lives_seen + 1;

   score_keeper dut (
      .clk          (clk),
      .rst          (rst),
      .MODE         (mode),
      .clear        (clear),
      .pellet_eaten (pellet),
      .power_eaten  (power),
      .fruit_eaten  (fruit),
      .ghost_eaten  (ghost),
      .score        (score),
      .high_score   (high_score),
      .busy         (busy),
      .drop         (drop),
      .extra_life   (extra_life)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] int2bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic m_add(input int pts);
      int nw;
      nw = m_score + pts;
      if (nw > 9999) nw = 9999;
      if (ExtraLife && !m_award && (m_score / 1000) == 0 && (nw / 1000) != 0) begin
         m_lives++;
         m_award = 1'b1;
      end
      m_score = nw;
      if (m_score > m_high) m_high = m_score;
   endtask

   task automatic m_events(input bit g, input bit pw, input bit f, input bit pe);
      if (pw) m_combo = 0;
      if (g) begin
         m_add(200 << m_combo);
         if (m_combo < 3) m_combo++;
      end
      if (pw) begin
         m_add(50);
         m_combo = 0;
      end
      if (f) m_add(100);
      if (pe) m_add(10);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      chk("busy_settles", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_score"}, {16'd0, score}, {16'd0, int2bcd(m_score)});
      chk({tag, "_high"}, {16'd0, high_score}, {16'd0, int2bcd(m_high)});
      chk({tag, "_drop"}, {31'd0, drop}, {31'd0, m_drop});
      chk({tag, "_lives"}, lives_seen, m_lives);
   endtask

   // dup: 1 repeats pellet, 2 repeats fruit on the following cycle (while still pending).
   task automatic fire(input bit g, input bit pw, input bit f, input bit pe, input int dup,
                       input logic [2:0] md);
      bit play, hit;
      play = !(md == 3'd0 || md == 3'd1 || md == 3'd3);
      hit  = (dup == 1 && pe) || (dup == 2 && f);
      mode = md;
      ghost = g; power = pw; fruit = f; pellet = pe;
      @(posedge clk); #1;
      ghost = 0; power = 0; fruit = 0; pellet = 0;
      if (hit) begin
         pellet = (dup == 1);
         fruit  = (dup == 2);
         @(posedge clk); #1;
         pellet = 0; fruit = 0;
      end
      if (play) begin
         m_events(g, pw, f, pe);
         if (hit) m_drop = 1'b1;
      end
      wait_idle();
      @(posedge clk); #1;
      mode = ModePlay;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      m_score = 0; m_combo = 0; m_award = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; clear = 0; pellet = 0; power = 0; fruit = 0; ghost = 0; mode = ModePlay;
      #12;
      chk("rst_score", {16'd0, score}, 32'd0);
      chk("rst_high", {16'd0, high_score}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_drop", {31'd0, drop}, 32'd0);
      chk("rst_extra", {31'd0, extra_life}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Single pellet: latency and busy window.
      pellet = 1'b1;
      @(posedge clk); #1;
      pellet = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         chk($sformatf("busy_e%0d", c), {31'd0, busy}, 32'd1);
         chk($sformatf("no_partial_e%0d", c), {16'd0, score}, 32'd0);
      end
      @(posedge clk); #1;
      chk("pellet_score_e6", {16'd0, score}, 32'h0010);
      chk("pellet_high_e6", {16'd0, high_score}, 32'd0);
      chk("busy_low_e6", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("pellet_high_e7", {16'd0, high_score}, 32'h0010);
      m_add(10);

      // Simultaneous ghost, power, pellet; then ghost restarts at 200.
      do_clear();
      fire(1, 1, 0, 1, 0, ModePlay);
      chk("combo_burst", {16'd0, score}, 32'h0260);
      fire(1, 0, 0, 0, 0, ModePlay);
      chk("combo_reset_ghost", {16'd0, score}, 32'h0460);
      check_model("burst");

      // Ghost chain saturation.
      do_clear();
      for (int i = 0; i < 5; i++) fire(1, 0, 0, 0, 0, ModePlay);
      chk("ghost_chain", {16'd0, score}, 32'h4600);
      check_model("chain");

      // Non-sampling modes ignore events and never set drop.
      fire(1, 1, 1, 1, 1, 3'd0);
      fire(1, 1, 1, 1, 2, 3'd1);
      fire(1, 1, 1, 1, 1, 3'd3);
      check_model("ignored");

      // Clear during ADD aborts and keeps high score.
      pellet = 1'b1;
      @(posedge clk); #1;
      pellet = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      do_clear();
      chk("clear_score", {16'd0, score}, 32'd0);
      chk("clear_busy", {31'd0, busy}, 32'd0);
      chk("clear_high", {16'd0, high_score}, 32'h4600);
      repeat (8) @(posedge clk);
      #1;
      check_model("after_clear");

      // Thousands crossing from 0990.
      for (int i = 0; i < 9; i++) fire(0, 0, 1, 0, 0, ModePlay);
      for (int i = 0; i < 9; i++) fire(0, 0, 0, 1, 0, ModePlay);
      chk("pre_cross", {16'd0, score}, 32'h0990);
      fire(0, 0, 1, 0, 0, ModePlay);
      chk("cross_score", {16'd0, score}, 32'h1090);
      fire(0, 0, 1, 0, 0, ModePlay);
      check_model("cross");

      // Saturation at 9999 and lost duplicate.
      do_clear();
      for (int i = 0; i < 8; i++) fire(1, 0, 0, 0, 0, ModePlay);
      for (int i = 0; i < 5; i++) fire(0, 0, 1, 0, 0, ModePlay);
      for (int i = 0; i < 9; i++) fire(0, 0, 0, 1, 0, ModePlay);
      chk("pre_sat", {16'd0, score}, 32'h9990);
      chk("drop_still_clear", {31'd0, drop}, 32'd0);
      fire(0, 0, 0, 1, 1, ModePlay);
      chk("sat_score", {16'd0, score}, 32'h9999);
      chk("dup_drop", {31'd0, drop}, 32'd1);
      check_model("sat");

      // Asynchronous reset mid-cycle while an addition is in flight.
      pellet = 1'b1;
      @(posedge clk); #1;
      pellet = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_score", {16'd0, score}, 32'd0);
      chk("arst_high", {16'd0, high_score}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_drop", {31'd0, drop}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_score = 0; m_high = 0; m_combo = 0; m_drop = 1'b0; m_award = 1'b0;

      // Randomized bursts.
      for (int i = 0; i < 40; i++) begin
         r_ev  = 4'($urandom);
         r_md  = ($urandom_range(0, 9) < 7) ? ModePlay : 3'($urandom_range(0, 4));
         r_dup = $urandom_range(0, 5);
         if ($urandom_range(0, 9) == 0) do_clear();
         fire(r_ev[3], r_ev[2], r_ev[1], r_ev[0], r_dup, r_md);
         check_model($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
